// File: rtl/mem_access_unit_if.sv
// CPU-side and memory-side signal bundle for mem_access_unit.
// The unit connects through the slave modport; the CPU/memory side uses master.
interface mem_access_unit_if #(
    parameter int IDX_W = 10
);
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             sign_ext;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      pc;
    logic             busy;
    logic             done;
    logic             addr_err;
    logic [31:0]      rdata;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_wen;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, pc, mem_rdata,
        output busy, done, addr_err, rdata, mem_addr, mem_wen, mem_wdata
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, pc, mem_rdata,
        input  busy, done, addr_err, rdata, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle byte/half/word load-store unit over a word memory with 1-cycle read.
// Optional MAU_WRITE_LOG_EN prints every memory write with the issuing PC.
module mem_access_unit #(
    parameter int IDX_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_RD, S_DATA, S_WR, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_sx;
    logic [1:0]       r_lane;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [IDX_W-1:0] r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic             w_accept;
    logic             w_misalign;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merge;

    assign w_accept   = (r_state == S_IDLE) && bus.req;
    assign w_misalign = (bus.size == 2'b11)
                      || ((bus.size == 2'b01) && bus.addr[0])
                      || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_misalign)                         w_next = S_ERR;
                    else if (bus.we && bus.size == 2'b10)   w_next = S_WR;
                    else                                    w_next = S_RD;
                end
            end
            S_ERR:   w_next = S_IDLE;
            S_RD:    w_next = S_DATA;
            S_DATA:  w_next = r_we ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane select and extension for loads, lane replacement for sub-word stores.
    always_comb begin
        w_byte  = bus.mem_rdata[8*r_lane +: 8];
        w_half  = bus.mem_rdata[16*r_lane[1] +: 16];
        w_load  = bus.mem_rdata;
        w_merge = r_wdata;
        case (r_size)
            2'b00: begin
                w_load  = {{24{r_sx & w_byte[7]}}, w_byte};
                w_merge = bus.mem_rdata;
                w_merge[8*r_lane +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_load  = {{16{r_sx & w_half[15]}}, w_half};
                w_merge = bus.mem_rdata;
                w_merge[16*r_lane[1] +: 16] = r_wdata[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sx        <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.we;
                r_size   <= bus.size;
                r_sx     <= bus.sign_ext;
                r_lane   <= bus.addr[1:0];
                r_wdata  <= bus.wdata;
                // Rejected requests leave the memory-side address untouched.
                if (!w_misalign) begin
                    r_mem_addr  <= bus.addr[IDX_W+1:2];
                    r_mem_wdata <= bus.wdata;
                end
            end
            if (r_state == S_DATA) begin
                if (r_we) r_mem_wdata <= w_merge;
                else      r_rdata     <= w_load;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_ERR) || (r_state == S_DONE);
    assign bus.addr_err  = (r_state == S_ERR);
    assign bus.mem_wen   = (r_state == S_WR);
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef MAU_WRITE_LOG_EN
    logic [31:0] r_pc;
    logic [31:0] r_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc   <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_pc   <= bus.pc;
            r_addr <= bus.addr;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_wen && !reset)
            $display("@%08h: *%08h <= %08h", r_pc, r_addr & ~32'h3, bus.mem_wdata);
    end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued at issue
// and popped when the unit signals done (or writes, for the back-to-back case).
module tb_mem_access_unit;
    localparam int IDX_W = 10;

    typedef struct {
        logic        err;
        int          lat;
        int          nwen;
        logic [31:0] wdat;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    logic clk;
    logic reset;
    mem_access_unit_if #(.IDX_W(IDX_W)) bus ();

    mem_access_unit #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [1024];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wen_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    always @(negedge clk) if (bus.mem_wen) wen_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input int lat, input int nwen,
                                input logic [31:0] wdat, input logic chk_rd,
                                input logic [31:0] rd);
        exp_t e;
        e.err = err; e.lat = lat; e.nwen = nwen; e.wdat = wdat;
        e.chk_rd = chk_rd; e.rd = rd;
        return e;
    endfunction

    task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = wd; bus.pc = pc;
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input exp_t e);
        exp_t   x;
        int     wen0;
        int     wen_at;
        logic [31:0] wdat;
        bit     got;
        @(negedge clk);
        drive(w, sz, sx, a, wd, 32'h1000 + a);
        @(posedge clk);
        #1 bus.req = 1'b0;
        sb.push_back(e);
        wen0 = wen_cnt;
        wen_at = -1;
        wdat = '0;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (n == 0 && !e.err)
                chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(a[IDX_W+1:2]));
            if (bus.mem_wen) begin
                wen_at = n;
                wdat = bus.mem_wdata;
            end
            if (bus.done) begin
                got = 1;
                x = sb.pop_front();
                chk({tag, " latency"}, n, x.lat);
                chk({tag, " addr_err"}, 32'(bus.addr_err), 32'(x.err));
                if (x.chk_rd) chk({tag, " rdata"}, bus.rdata, x.rd);
                chk({tag, " wen count"}, wen_cnt - wen0, x.nwen);
                if (x.nwen > 0) begin
                    chk({tag, " mem_wdata"}, wdat, x.wdat);
                    chk({tag, " wen->done"}, n - wen_at, 1);
                end
            end
        end
        if (!got) begin
            chk({tag, " done timeout"}, 0, 1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int   pos [$];
        exp_t x;
        bit   acc;
        reset = 1'b1;
        bus.req = 0; bus.we = 0; bus.size = 0; bus.sign_ext = 0;
        bus.addr = 0; bus.wdata = 0; bus.pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst addr_err", 32'(bus.addr_err), 0);
        chk("rst mem_wen", 32'(bus.mem_wen), 0);
        chk("rst rdata", bus.rdata, 0);
        chk("rst mem_addr", 32'(bus.mem_addr), 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;

        run("sw init",  1, 2'b10, 0, 32'h10, 32'h8899AABB, mk(0, 1, 1, 32'h8899AABB, 0, 0));
        run("lw",       0, 2'b10, 1, 32'h10, 0, mk(0, 2, 0, 0, 1, 32'h8899AABB));
        run("lb sx",    0, 2'b00, 1, 32'h12, 0, mk(0, 2, 0, 0, 1, 32'hFFFFFF99));
        run("lbu",      0, 2'b00, 0, 32'h12, 0, mk(0, 2, 0, 0, 1, 32'h00000099));
        run("lh sx",    0, 2'b01, 1, 32'h12, 0, mk(0, 2, 0, 0, 1, 32'hFFFF8899));
        run("lhu lo",   0, 2'b01, 0, 32'h10, 0, mk(0, 2, 0, 0, 1, 32'h0000AABB));
        run("sh",       1, 2'b01, 0, 32'h12, 32'h00001234, mk(0, 3, 1, 32'h1234AABB, 0, 0));
        run("sb hi",    1, 2'b00, 0, 32'h13, 32'hFFFFFF5A, mk(0, 3, 1, 32'h5A34AABB, 0, 0));
        run("lb b1",    0, 2'b00, 1, 32'h11, 0, mk(0, 2, 0, 0, 1, 32'hFFFFFFAA));
        run("lw mis",   0, 2'b10, 0, 32'h13, 0, mk(1, 0, 0, 0, 1, 32'hFFFFFFAA));
        run("sh mis",   1, 2'b01, 0, 32'h11, 32'hFFFF, mk(1, 0, 0, 0, 0, 0));
        run("size11",   1, 2'b11, 0, 32'h10, 32'h1, mk(1, 0, 0, 0, 1, 32'hFFFFFFAA));
        run("lw after", 0, 2'b10, 0, 32'h10, 0, mk(0, 2, 0, 0, 1, 32'h5A34AABB));

        // Reset while the byte store sits in DATA.
        begin
            int wen0;
            wen0 = wen_cnt;
            @(negedge clk);
            drive(1, 2'b00, 0, 32'h15, 32'h000000A5, 32'h2000);
            @(posedge clk);
            #1 bus.req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk("mid rst busy", 32'(bus.busy), 0);
            chk("mid rst done", 32'(bus.done), 0);
            chk("mid rst mem_wen", 32'(bus.mem_wen), 0);
            chk("mid rst rdata", bus.rdata, 0);
            chk("mid rst mem_addr", 32'(bus.mem_addr), 0);
            chk("mid rst mem_wdata", bus.mem_wdata, 0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            drive(0, 2'b10, 0, 32'h10, 0, 32'h2004);
            @(posedge clk);
            #1;
            chk("post rst accept", 32'(bus.busy), 1);
            bus.req = 1'b0;
            repeat (4) @(negedge clk);
            chk("post rst rdata", bus.rdata, 32'h5A34AABB);
            chk("mid rst no wen", wen_cnt - wen0, 0);
            chk("mid rst mem5", mem[5], 32'h0);
        end

        // Two stores with req held high: second accepted after DONE->IDLE.
        begin
            int wen0;
            wen0 = wen_cnt;
            @(negedge clk);
            drive(1, 2'b10, 0, 32'h30, 32'h11111111, 32'h100);
            sb.push_back(mk(0, 0, 1, 32'h11111111, 0, 0));
            @(posedge clk);
            #1 drive(1, 2'b10, 0, 32'h34, 32'h22222222, 32'h104);
            sb.push_back(mk(0, 3, 1, 32'h22222222, 0, 0));
            acc = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (bus.mem_wen) begin
                    pos.push_back(n);
                    if (sb.size() > 0) begin
                        x = sb.pop_front();
                        chk("b2b wen pos", n, x.lat);
                        chk("b2b wdata", bus.mem_wdata, x.wdat);
                    end else chk("b2b extra wen", 1, 0);
                end
                if (n == 3) bus.req = 1'b0;
            end
            bus.req = 1'b0;
            if (sb.size() != 0) chk("b2b missing wen", sb.size(), 0);
            chk("b2b wen count", wen_cnt - wen0, 2);
            chk("b2b mem12", mem[12], 32'h11111111);
            chk("b2b mem13", mem[13], 32'h22222222);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the CPU datapath and a word-organised data memory with one-cycle synchronous read. Accepts byte, halfword and word load/store requests. Sub-word stores use read-modify-write on the word memory. Loads are zero- or sign-extended. Misaligned requests are reported as an error and never reach memory.

## Interface
- `IDX_W`, default 10: word-index width driven to the memory (1024 words).
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: asynchronous, active-high; forces every register and output to its reset value immediately.
- `req` in 1: request valid; sampled only while `busy`=0.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as error).
- `sign_ext` in 1: loads sign-extend when 1, zero-extend when 0.
- `addr` in 32: byte address.
- `wdata` in 32: store data; the low 8/16/32 bits are used.
- `pc` in 32: PC of the issuing instruction, used only by the logging option.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `addr_err` out 1: high together with `done` when the request was rejected.
- `rdata` out 32: extended load result; holds its value until the next successful load completes.
- `mem_addr` out IDX_W: word index, equal to `addr[IDX_W+1:2]` of the captured request.
- `mem_wen` out 1: memory write enable, one cycle.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_addr` is presented.

## Operation
- Reset values: state IDLE; `busy`, `done`, `addr_err`, `mem_wen` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0.
- Acceptance: in IDLE with `req`=1, the unit captures `we`, `size`, `sign_ext`, `addr`, `wdata` and `pc`.
- Error check at acceptance: the request is rejected when any of these holds:
  - `size`=11;
  - `size`=01 and `addr[0]`=1;
  - `size`=10 and `addr[1:0]`≠00.
- States: IDLE, ERR, RD, DATA, WR, DONE.
- Rejected request: IDLE→ERR→IDLE. In ERR, `done`=1 and `addr_err`=1. No memory address or write activity is produced.
- Word store: IDLE→WR→DONE→IDLE. In WR, `mem_wen`=1 and `mem_wdata`=`wdata`.
- Byte/half store: IDLE→RD→DATA→WR→DONE→IDLE.
  - At the end of DATA, the merge word is registered: the selected lane of `mem_rdata` is replaced by the low bits of `wdata`; all other bits keep their read value.
- Load: IDLE→RD→DATA→DONE→IDLE.
  - At the end of DATA, the selected lane is extracted, extended, and registered into `rdata`.
- Lanes are little-endian:
  - byte `addr[1:0]`=k occupies bits [8k+7:8k];
  - half `addr[1]`=h occupies bits [16h+15:16h].
- Sign extension replicates the lane MSB. Word loads ignore `sign_ext`.
- `mem_addr` is registered at acceptance and held stable through DONE.
- DONE: `done`=1 and `addr_err`=0. For a load, `rdata` is already valid in this cycle.
- While `busy`=1, `req` is ignored with no queuing. DONE counts as busy, so the earliest next acceptance is the IDLE cycle that follows.
- Reset mid-operation: the operation is aborted and the unit returns to IDLE.
  - Any pending write is dropped.
  - A `mem_wen` that is high falls with `reset`.
  - `rdata` is cleared.

## Timing
- Edge 0 is the posedge that samples `req` in IDLE.
- Word store: `mem_wen` high in the cycle after edge 0; `done` in the cycle after edge 1.
- Byte/half store: `mem_wen` in the cycle after edge 2; `done` in the cycle after edge 3.
- Load: `done` and valid `rdata` in the cycle after edge 2.
- Error: `done` and `addr_err` in the cycle after edge 0.
- Back-to-back throughput: one request per (latency + 1) cycles, because IDLE lasts at least one cycle between requests.

## Configuration
- `MAU_WRITE_LOG_EN` defined: at every posedge where `mem_wen`=1 and `reset`=0, the simulator prints `@<pc>: *<addr & ~3> <= <mem_wdata>` (hex, 8 digits each), using the captured `pc`.
- `MAU_WRITE_LOG_EN` undefined: no `$display`; the `pc` port remains present but unused. Cycle behaviour is identical in both builds.

## Test plan
- Load word: memory word 0x4 = 0x8899AABB; load word at `addr`=0x10. Expect:
  - `mem_addr`=4;
  - `done` two cycles after acceptance;
  - `rdata`=0x8899AABB.
- Signed/unsigned byte: same memory word; load byte at `addr`=0x12.
  - With `sign_ext`=1, expect `rdata`=0xFFFFFF99.
  - With `sign_ext`=0, expect `rdata`=0x00000099.
- Store half: word 0x4 = 0x8899AABB; store half `wdata`=0x1234 at `addr`=0x12. Expect:
  - a single `mem_wen` pulse with `mem_wdata`=0x1234AABB;
  - `done` one cycle later.
- Misaligned access: word access at `addr`=0x13 and half access at `addr`=0x11. Expect:
  - `done`=`addr_err`=1 in the cycle after acceptance;
  - `mem_wen` never asserted.
- Reset mid-RMW: assert `reset` while in DATA during a byte store. Expect:
  - no `mem_wen`;
  - all outputs 0 immediately;
  - a new `req` is accepted in the first cycle after `reset` deasserts.
- Busy ignore: hold `req`=1 continuously with two different stores. Expect:
  - the second is accepted only after DONE→IDLE;
  - exactly two `mem_wen` pulses;
  - with the macro defined, two log lines with the correct `pc`.
